// File: rtl/nco_pkg.sv
// Shared types, default widths and helper functions
// for the multi-channel NCO.
package nco_pkg;

    localparam int NUM_CH_D  = 4;
    localparam int PHASE_W_D = 32;
    localparam int ADDR_W_D  = 10;
    localparam int OUT_W_D   = 16;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Rounded 2^32 * f / fs.
    function automatic logic [31:0] inc_for(
        input int unsigned f,
        input int unsigned fs
    );
        logic [63:0] num;
        num = ({32'd0, f} << 32) + 64'(fs / 2);
        return 32'(num / 64'(fs));
    endfunction

    // Quarter-wave entry with half-LSB phase offset.
    function automatic int sine_val(
        input int i,
        input int addr_w,
        input int out_w
    );
        real x;
        real span;
        span = real'(1 << (addr_w + 1));
        x = $sin((real'(i) + 0.5) * 3.14159265358979 / span);
        return $rtoi(x * real'((1 << (out_w - 1)) - 1) + 0.5);
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table with registered read,
// contents computed at elaboration.
module sine_quarter_rom
    import nco_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 15
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rom_tab [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_tab
        localparam int V = sine_val(i, ADDR_W, DATA_W + 1);
        assign rom_tab[i] = DATA_W'(V);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data <= rom_tab[addr];
        end
    end

endmodule

// File: rtl/nco_multichannel.sv
// Time-multiplexed multi-channel NCO sharing one
// quarter-wave ROM, valid/ready sample output.
module nco_multichannel
    import nco_pkg::*;
#(
    parameter int  NUM_CH  = NUM_CH_D,
    parameter int  PHASE_W = PHASE_W_D,
    parameter int  ADDR_W  = ADDR_W_D,
    parameter int  OUT_W   = OUT_W_D,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_tick,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic               cfg_en,
    input  logic               cfg_phase_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_W-1:0]    out_ch,
    output logic [OUT_W-1:0]   out_sample,
    output logic               busy,
    output logic               overrun
);

    state_t             state;
    logic [CH_W-1:0]    ch_cnt;
    logic [PHASE_W-1:0] acc [NUM_CH];
    logic [PHASE_W-1:0] inc [NUM_CH];
    logic [NUM_CH-1:0]  en;

    logic adv;
    logic issue;
    logic last_ch;

    logic              s0_valid;
    logic              s0_en;
    logic [CH_W-1:0]   s0_ch;
    logic [1:0]        s0_q;
    logic [ADDR_W-1:0] s0_a;

    logic            s1_valid;
    logic            s1_en;
    logic [CH_W-1:0] s1_ch;
    logic [1:0]      s1_q;

    logic [ADDR_W-1:0] rom_addr;
    logic [OUT_W-2:0]  rom_data;
    logic [OUT_W-1:0]  mag;
    logic [OUT_W-1:0]  samp;

    assign adv     = !(out_valid && !out_ready);
    assign busy    = (state == RUN) || s0_valid
                   || s1_valid || out_valid;
    assign issue   = (state == RUN) && adv;
    assign last_ch = (ch_cnt == CH_W'(NUM_CH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ch_cnt  <= '0;
            overrun <= 1'b0;
        end else begin
            if (sample_tick && busy) begin
                overrun <= 1'b1;
            end
            if (state == IDLE) begin
                if (sample_tick && !busy) begin
                    state  <= RUN;
                    ch_cnt <= '0;
                end
            end else if (adv) begin
                if (last_ch) begin
                    state <= IDLE;
                end else begin
                    ch_cnt <= ch_cnt + 1'b1;
                end
            end
        end
    end

    // A clear in the same cycle as the issue wins over the accumulate.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                inc[i] <= '0;
            end
            en <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_we && cfg_phase_clr
                    && cfg_ch == CH_W'(i)) begin
                    acc[i] <= '0;
                end else if (issue && en[i]
                    && ch_cnt == CH_W'(i)) begin
                    acc[i] <= acc[i] + inc[i];
                end
                if (cfg_we && cfg_ch == CH_W'(i)) begin
                    inc[i] <= cfg_inc;
                    en[i]  <= cfg_en;
                end
            end
        end
    end

    always_comb begin
        rom_addr = s0_a;
        unique case (s0_q)
            Q0, Q2: rom_addr = s0_a;
            Q1, Q3: rom_addr = ~s0_a;
            default: rom_addr = s0_a;
        endcase
    end

    sine_quarter_rom #(
        .ADDR_W(ADDR_W),
        .DATA_W(OUT_W - 1)
    ) u_rom (
        .clk (clk),
        .en  (adv),
        .addr(rom_addr),
        .data(rom_data)
    );

    assign mag = {1'b0, rom_data};

    always_comb begin
        samp = mag;
        unique case (s1_q)
            Q0, Q1: samp = mag;
            Q2, Q3: samp = -mag;
            default: samp = mag;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid   <= 1'b0;
            s0_en      <= 1'b0;
            s0_ch      <= '0;
            s0_q       <= '0;
            s0_a       <= '0;
            s1_valid   <= 1'b0;
            s1_en      <= 1'b0;
            s1_ch      <= '0;
            s1_q       <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_sample <= '0;
        end else if (adv) begin
            s0_valid <= issue;
            s0_en    <= en[ch_cnt];
            s0_ch    <= ch_cnt;
            s0_q     <= acc[ch_cnt][PHASE_W-1 -: 2];
            s0_a     <= acc[ch_cnt][PHASE_W-3 -: ADDR_W];
            s1_valid <= s0_valid;
            s1_en    <= s0_en;
            s1_ch    <= s0_ch;
            s1_q     <= s0_q;
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_ch     <= s1_ch;
                out_sample <= s1_en ? samp : '0;
            end
        end
    end

endmodule

// File: tb/tb_nco_multichannel.sv
// Scoreboard bench for nco_multichannel: table vectors
// plus stall, overrun, phase-clear and reset sequences.
module tb_nco_multichannel;
    import nco_pkg::*;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [31:0] cfg_inc = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_phase_clr = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] out_sample;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    nco_multichannel dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_inc      (cfg_inc),
        .cfg_en       (cfg_en),
        .cfg_phase_clr(cfg_phase_clr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ch       (out_ch),
        .out_sample   (out_sample),
        .busy         (busy),
        .overrun      (overrun)
    );

    typedef struct {
        int ch;
        int s;
    } exp_t;

    typedef struct {
        logic [31:0] inc;
        logic        en;
        int          exp0;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;

    logic [31:0] m_acc [NCH];
    logic [31:0] m_inc [NCH];
    logic        m_en  [NCH];

    bit          sc_on = 0;
    bit          have_prev = 0;
    bit          prev_neg = 0;
    int          sc = 0;
    bit          prev_stall = 0;
    logic [1:0]  st_ch;
    logic [15:0] st_s;

    function automatic int rom_m(input int i);
        real x;
        x = $sin((real'(i) + 0.5) * 3.14159265358979 / 2048.0);
        return $rtoi(x * 32767.0 + 0.5);
    endfunction

    function automatic int samp_m(input logic [31:0] ph, input logic e);
        logic [9:0] a;
        int v;
        a = ph[29:20];
        if (ph[30]) a = ~a;
        v = rom_m(int'(a));
        if (!e) return 0;
        return ph[31] ? -v : v;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_round();
        for (int c = 0; c < NCH; c++) begin
            exp_q.push_back('{c, samp_m(m_acc[c], m_en[c])});
            if (m_en[c]) m_acc[c] += m_inc[c];
        end
    endtask

    task automatic cfg(input int ch, input logic [31:0] inc,
                       input logic e, input logic clr);
        @(posedge clk);
        #1;
        cfg_we = 1'b1;
        cfg_ch = 2'(ch);
        cfg_inc = inc;
        cfg_en = e;
        cfg_phase_clr = clr;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        cfg_phase_clr = 1'b0;
        m_inc[ch] = inc;
        m_en[ch] = e;
        if (clr) m_acc[ch] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: queue=%0d busy=%0b, expected drained",
                     name, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || out_ch !== st_ch || out_sample !== st_s) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b ch=%0d s=%0d, expected v=1 ch=%0d s=%0d",
                             out_valid, out_ch, $signed(out_sample), st_ch, $signed(st_s));
                end
            end
            prev_stall = out_valid && !out_ready;
            st_ch = out_ch;
            st_s = out_sample;
            if (out_valid && out_ready) begin
                accepted++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample: got ch=%0d s=%0d, expected none",
                             out_ch, $signed(out_sample));
                end else begin
                    mon_e = exp_q.pop_front();
                    if (int'(out_ch) != mon_e.ch
                        || int'($signed(out_sample)) != mon_e.s) begin
                        errors++;
                        $display("FAIL sample: got ch=%0d s=%0d, expected ch=%0d s=%0d",
                                 out_ch, $signed(out_sample), mon_e.ch, mon_e.s);
                    end
                end
                if (sc_on && out_ch == 2'd0) begin
                    if (have_prev && ($signed(out_sample) < 0) != prev_neg) sc++;
                    prev_neg = $signed(out_sample) < 0;
                    have_prev = 1;
                end
            end
        end
    end

    initial begin
        vec_t tab [9];
        int   base;
        int   n;

        tab = '{
            '{32'h4000_0000, 1'b1, 25},
            '{32'h4000_0000, 1'b1, 32767},
            '{32'h4000_0000, 1'b1, -25},
            '{32'h4000_0000, 1'b1, -32767},
            '{32'h0000_0000, 1'b1, 25},
            '{32'h8000_0000, 1'b0, 0},
            '{32'h8000_0000, 1'b1, 25},
            '{32'h8000_0000, 1'b1, -25},
            '{32'h8000_0000, 1'b1, 25}
        };
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = '0;
            m_inc[c] = '0;
            m_en[c] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_sample", out_sample, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("inc_for_440", inc_for(440, 48000), 32'h0258_BF26);
        reset = 1'b0;

        foreach (tab[k]) begin
            cfg(0, tab[k].inc, tab[k].en, 1'b0);
            exp_q.push_back('{0, tab[k].exp0});
            for (int c = 1; c < NCH; c++) exp_q.push_back('{c, 0});
            if (tab[k].en) m_acc[0] += tab[k].inc;
            tick();
            wait_drain("table");
        end

        cfg(0, 32'd393705340, 1'b1, 1'b1);
        sc_on = 1;
        have_prev = 0;
        sc = 0;
        repeat (2400) begin
            push_round();
            tick();
            wait_drain("freq");
        end
        sc_on = 0;
        checks++;
        if (sc < 439 || sc > 441) begin
            errors++;
            $display("FAIL sign_changes: got %0d, expected 440 +/- 1", sc);
        end

        cfg(0, 32'h0100_0000, 1'b1, 1'b0);
        cfg(1, 32'h0234_5678, 1'b1, 1'b0);
        cfg(2, 32'h1000_0001, 1'b1, 1'b0);
        cfg(3, 32'hFFFF_FFFF, 1'b1, 1'b0);
        repeat (2) begin
            push_round();
            base = accepted;
            tick();
            n = 0;
            while (accepted < base + 2 && n < 50) begin
                @(posedge clk);
                n++;
            end
            chk("stall_start_timeout", n < 50, 1);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
            wait_drain("stall");
        end

        chk("overrun_before", overrun, 0);
        push_round();
        @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        chk("overrun_set", overrun, 1);
        wait_drain("overrun");
        repeat (3) @(posedge clk);
        #1;
        chk("no_extra_round", out_valid, 0);
        for (int c = 0; c < NCH; c++) chk("acc_once", dut.acc[c], m_acc[c]);

        push_round();
        @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        @(posedge clk);
        #1;
        cfg_we = 1'b1;
        cfg_ch = 2'd1;
        cfg_inc = m_inc[1];
        cfg_en = 1'b1;
        cfg_phase_clr = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        cfg_phase_clr = 1'b0;
        m_acc[1] = '0;
        wait_drain("clr");
        chk("clr_acc1", dut.acc[1], 0);
        push_round();
        tick();
        wait_drain("clr_next");

        tick();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        for (int c = 0; c < NCH; c++) chk("mid_rst_acc", dut.acc[c], 0);
        exp_q.delete();
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = '0;
            m_inc[c] = '0;
            m_en[c] = 1'b0;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        cfg(0, 32'h4000_0000, 1'b1, 1'b0);
        push_round();
        @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 3);
        wait_drain("post_rst");

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
